// File: rtl/voice_mixer.sv
// ---------------------------------------------------------------------------
// voice_mixer
//
// Collects one sample per frame from each of NUM_VOICES note players and
// sums them with saturation. The mixed sample is presented to the echo stage
// with a single-cycle strobe. A timeout forces a mix when a voice stalls, so
// frames keep moving.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   voice_sample        NUM_VOICES*WIDTH, voice i at [i*WIDTH +: WIDTH]
//   voice_sample_ready  NUM_VOICES one-cycle strobes, sample valid same cycle
//   voice_active        NUM_VOICES mask; inactive voices are ignored and add 0
//   note_sample_out     WIDTH mixed, saturated sample, held between mixes
//   note_sample_ready   one-cycle strobe, high while note_sample_out is new
// ---------------------------------------------------------------------------
module voice_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_VOICES*WIDTH-1:0]   voice_sample,
    input  logic [NUM_VOICES-1:0]         voice_sample_ready,
    input  logic [NUM_VOICES-1:0]         voice_active,
    output logic [WIDTH-1:0]              note_sample_out,
    output logic                          note_sample_ready
);

    // The accumulator is wide enough that a sum of NUM_VOICES full-scale
    // samples can never wrap before saturation.
    localparam int ACC_W = WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int IDX_W = $clog2(NUM_VOICES + 1);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SUM,
        S_OUT
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [WIDTH-1:0]       lat_reg  [NUM_VOICES];
    logic [WIDTH-1:0]       snap_reg [NUM_VOICES];
    logic [NUM_VOICES-1:0]  got_reg;
    logic [NUM_VOICES-1:0]  strobe;

    logic [ACC_W-1:0]       acc_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [WIDTH-1:0]       out_reg;
    logic                   ready_reg;

    logic                   complete;
    logic                   cnt_clr;
    logic                   cnt_inc;
    logic                   sum_start;
    logic                   acc_add;
    logic                   out_load;
    logic [WIDTH-1:0]       sel_sample;
    logic [WIDTH-1:0]       sat_sample;

    assign strobe   = voice_sample_ready & voice_active;
    // Uses the live mask every cycle, so dropping a voice mid-frame can
    // complete the frame without waiting for it.
    assign complete = &(got_reg | ~voice_active);

    // -----------------------------------------------------------------------
    // Per-voice latch, arrival flag and snapshot
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lat_reg[gi]  <= '0;
                    got_reg[gi]  <= 1'b0;
                    snap_reg[gi] <= '0;
                end else begin
                    // A strobe on the SUM entry edge belongs to the next
                    // frame: its flag survives the clear, and the snapshot
                    // still takes the previous latch contents.
                    if (strobe[gi]) begin
                        lat_reg[gi] <= voice_sample[gi*WIDTH +: WIDTH];
                        got_reg[gi] <= 1'b1;
                    end else if (sum_start) begin
                        got_reg[gi] <= 1'b0;
                    end
                    if (sum_start) begin
                        snap_reg[gi] <= voice_active[gi] ? lat_reg[gi] : '0;
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and datapath controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        sum_start  = 1'b0;
        acc_add    = 1'b0;
        out_load   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (|got_reg) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                cnt_inc = 1'b1;
                if (complete || (cnt_reg == CNT_W'(TIMEOUT - 1))) begin
                    state_next = S_SUM;
                    sum_start  = 1'b1;
                end
            end
            S_SUM: begin
                // One voice per cycle; the cycle after the last add loads
                // the output.
                if (idx_reg == IDX_W'(NUM_VOICES)) begin
                    state_next = S_OUT;
                    out_load   = 1'b1;
                end else begin
                    acc_add = 1'b1;
                end
            end
            S_OUT: begin
                cnt_clr = 1'b1;
                if (|got_reg) begin
                    state_next = S_COLLECT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Snapshot selected by the running index.
    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                sel_sample = snap_reg[i];
            end
        end
    end

    // Clamp: the sum fits in WIDTH bits only when every bit above the
    // result's sign bit matches the accumulator sign.
    always_comb begin
        if (acc_reg[ACC_W-1:WIDTH-1] == {(ACC_W-WIDTH+1){acc_reg[ACC_W-1]}}) begin
            sat_sample = acc_reg[WIDTH-1:0];
        end else if (acc_reg[ACC_W-1]) begin
            sat_sample = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat_sample = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // -----------------------------------------------------------------------
    // Counter, accumulator and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            idx_reg   <= '0;
            out_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (sum_start) begin
                acc_reg <= '0;
                idx_reg <= '0;
            end else if (acc_add) begin
                acc_reg <= acc_reg + {{(ACC_W-WIDTH){sel_sample[WIDTH-1]}}, sel_sample};
                idx_reg <= idx_reg + 1'b1;
            end

            if (out_load) begin
                out_reg <= sat_sample;
            end
            ready_reg <= out_load;
        end
    end

    assign note_sample_out   = out_reg;
    assign note_sample_ready = ready_reg;

endmodule

// File: tb/tb_voice_mixer.sv
// ---------------------------------------------------------------------------
// tb_voice_mixer
//
// Directed stimulus with a scoreboard. Each frame pushes its hand-computed
// mix value and the edge at which note_sample_ready must rise; a separate
// monitor pops and compares whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_voice_mixer;

    localparam int NV = 3;
    localparam int W  = 16;
    localparam int TO = 64;

    logic              clk;
    logic              rst_n;
    logic [NV*W-1:0]   voice_sample;
    logic [NV-1:0]     voice_sample_ready;
    logic [NV-1:0]     voice_active;
    logic [W-1:0]      note_sample_out;
    logic              note_sample_ready;

    voice_mixer #(
        .NUM_VOICES (NV),
        .WIDTH      (W),
        .TIMEOUT    (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .voice_sample       (voice_sample),
        .voice_sample_ready (voice_sample_ready),
        .voice_active       (voice_active),
        .note_sample_out    (note_sample_out),
        .note_sample_ready  (note_sample_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] val;
        int           edge_no;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    logic prev_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (note_sample_ready) begin
            tests++;
            if (prev_ready) begin
                fails++;
                $display("FAIL ready_width: ready high on two consecutive edges at edge %0d (required one cycle)", cyc);
            end
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: strobe at edge %0d out=%0d, none required", cyc, $signed(note_sample_out));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("[TB] %s: out=%0d at edge %0d (expect %0d at edge %0d)",
                         e.name, $signed(note_sample_out), cyc, $signed(e.val), e.edge_no);
                tests++;
                if (note_sample_out !== e.val) begin
                    fails++;
                    $display("FAIL %s_value: got %0d, required %0d", e.name, $signed(note_sample_out), $signed(e.val));
                end
                tests++;
                if (cyc != e.edge_no) begin
                    fails++;
                    $display("FAIL %s_latency: ready at edge %0d, required edge %0d", e.name, cyc, e.edge_no);
                end
            end
        end
        prev_ready = note_sample_ready;
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    function automatic logic [NV*W-1:0] pk(input int a, input int b, input int c);
        return {c[W-1:0], b[W-1:0], a[W-1:0]};
    endfunction

    // Strobe the voices in m with vals; t returns the sampling edge number.
    task automatic strobe_mask(input logic [NV-1:0] m, input logic [NV*W-1:0] vals, output int t);
        @(negedge clk);
        voice_sample       = vals;
        voice_sample_ready = m;
        @(posedge clk);
        #1;
        t = cyc;
        voice_sample_ready = '0;
    endtask

    task automatic push(input int v, input int edge_no, input string name);
        exp_t e;
        e.val     = v[W-1:0];
        e.edge_no = edge_no;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d outputs still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Frame whose last voices strobe while the FSM already collects:
    // ready rises NV+2 edges after the last strobe.
    task automatic frame(input int a, input int b, input int c, input int sum, input string name);
        int t;
        strobe_mask(3'b001, pk(a, 0, 0), t);
        repeat (2) @(negedge clk);
        strobe_mask(3'b110, pk(0, b, c), t);
        push(sum, t + NV + 2, name);
        drain(name);
    endtask

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        int t;
        rst_n              = 1'b0;
        voice_sample       = '0;
        voice_sample_ready = '0;
        voice_active       = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (note_sample_out !== '0) begin
            fails++;
            $display("FAIL reset_out: got %0d, required 0", $signed(note_sample_out));
        end
        tests++;
        if (note_sample_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %0b, required 0", note_sample_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic mix: 1000 + 2000 - 500.
        strobe_mask(3'b001, pk(1000, 0, 0), t);
        repeat (2) @(negedge clk);
        strobe_mask(3'b010, pk(0, 2000, 0), t);
        repeat (6) @(negedge clk);
        strobe_mask(3'b100, pk(0, 0, -500), t);
        push(2500, t + 5, "basic");
        drain("basic");

        // Saturation.
        frame(20000, 20000, 20000, 32767, "sat_pos");
        frame(-20000, -20000, -20000, -32768, "sat_neg");
        frame(32767, 1, 0, 32767, "sat_edge");

        // Masking: v1 strobes 7000 but is inactive.
        voice_active = 3'b101;
        strobe_mask(3'b001, pk(1500, 0, 0), t);
        strobe_mask(3'b010, pk(0, 7000, 0), t);
        strobe_mask(3'b100, pk(0, 0, -300), t);
        push(1200, t + 5, "mask");
        drain("mask");
        voice_active = 3'b111;

        // Prior frame, then a timed-out frame reusing v1/v2 latches.
        frame(10, 200, 300, 510, "prior");
        strobe_mask(3'b001, pk(100, 0, 0), t);
        // COLLECT is entered at t+1; ready TIMEOUT+NV+1 edges later.
        push(600, t + 1 + TO + NV + 1, "timeout");
        drain("timeout");

        // Overlap: new values strobe during SUM of the current frame.
        strobe_mask(3'b001, pk(1, 0, 0), t);
        repeat (2) @(negedge clk);
        strobe_mask(3'b110, pk(0, 2, 3), t);
        push(6, t + 5, "overlap_a");
        // OUT at t+5, COLLECT t+6, SUM t+7, accumulate, OUT t+7+NV+1.
        push(60, t + 7 + NV + 1, "overlap_b");
        @(negedge clk);
        strobe_mask(3'b111, pk(10, 20, 30), t);
        drain("overlap");

        // Reset mid-SUM aborts the frame.
        strobe_mask(3'b001, pk(5, 0, 0), t);
        repeat (2) @(negedge clk);
        strobe_mask(3'b110, pk(0, 6, 7), t);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (note_sample_out !== '0) begin
            fails++;
            $display("FAIL reset_mid_out: got %0d, required 0", $signed(note_sample_out));
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // After reset v1 latch is zero: timed-out mix of 11 + 0 + 33.
        strobe_mask(3'b001, pk(11, 0, 0), t);
        push(44, t + 1 + TO + NV + 1, "post_reset");
        repeat (3) @(negedge clk);
        strobe_mask(3'b100, pk(0, 0, 33), t);
        drain("post_reset");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
